seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
Parametrised serial pattern detector. It is the successor to the fixed two-bit Mealy detector, with programmable pattern width, pattern value, don't-care mask and overlap mode.
- Samples one bit per valid cycle.
- Pulses a registered detect when the last PATTERN_W accepted bits match the programmed pattern.
- Sits on serial bitstreams, such as frame-sync and preamble search, between a deserialiser and downstream framing logic.

Parameters:
PATTERN_W, 4, pattern length in bits (legal range 2..32)
PATTERN_RST, 4'b1011, pattern value loaded at reset (PATTERN_W bits)
CNT_W, 8, match counter width (only used with the optional feature)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  inbit is sampled this cycle
inbit  input  1  serial data bit
overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after each match
cfg_load  input  1  load cfg_pattern/cfg_mask this cycle
cfg_pattern  input  PATTERN_W  new pattern; MSB is the oldest bit in time
cfg_mask  input  PATTERN_W  per-bit compare enable; 0 = don't care
detect  output  1  one-cycle match pulse (registered)
armed  output  1  history holds PATTERN_W valid bits
match_count  output  CNT_W  saturating match count (MATCH_COUNT_EN only)
count_clr  input  1  synchronous clear of match_count (MATCH_COUNT_EN only)

Behaviour:
- Reset (reset_n low, asynchronous):
  - hist=0, fill=0, pattern_q=PATTERN_RST, mask_q=all ones.
  - detect=0, armed=0, state=EMPTY, match_count=0.
- Shift on accepted bit: on in_valid=1, hist <= {hist[PATTERN_W-2:0], inbit}. The newest bit enters at the LSB.
- FSM states:
  - EMPTY (fill=0).
  - FILLING (0<fill<PATTERN_W).
  - ARMED (fill=PATTERN_W). armed = (state==ARMED).
- Fill rules: fill increments on each accepted bit and saturates at PATTERN_W.
  - EMPTY->FILLING on first bit.
  - FILLING->ARMED when the PATTERN_W-th bit is accepted.
- Match term, evaluated combinationally on the next-history value:
  - match = in_valid & (fill+1 >= PATTERN_W) & (((next_hist ^ pattern_q) & mask_q) == 0).
  - A match is possible on the very bit that completes the fill.
- Output timing:
  - detect <= match. It is high for exactly the one cycle after the completing bit is sampled: 1-cycle latency, Mealy-registered.
  - detect=0 in any cycle where in_valid=0.
- Overlap mode:
  - overlap=1: after a match, state stays ARMED; the next bit can match again.
  - overlap=0: after a match, fill <= 0, hist <= 0, state <= EMPTY. A full fresh PATTERN_W bits are needed before the next match.
- overlap is sampled per accepted bit. Changing it mid-stream takes effect on the next accepted bit; no history flush.
- Config load:
  - cfg_load=1 loads pattern_q/mask_q and forces fill=0, hist=0, state=EMPTY.
  - detect <= 0 in that cycle.
  - If cfg_load and in_valid coincide, load wins and the bit is discarded.
- mask_q all zeros: every bit is don't-care, so every accepted bit once ARMED matches. Legal.
- Reset mid-stream: all history is lost immediately. The first match is possible no earlier than PATTERN_W accepted bits after reset_n deasserts.
- No combinational path from inputs to detect or armed.

Optional Feature:
MATCH_COUNT_EN.
- Defined:
  - match_count increments by 1 on every cycle where detect is set and saturates at 2^CNT_W-1.
  - count_clr=1 clears it to 0. Clear wins over a coincident increment.
  - cfg_load does not affect the count.
- Undefined: match_count is driven to 0, count_clr is ignored, and no counter flops are inferred.

Test Plan:
- Reset value and basic match: after reset, default pattern 1011. Stream 1,0,1,1 on consecutive valid cycles, overlap=1 -> detect=1 exactly one cycle after the 4th bit; armed=1 from the 4th bit onward.
- Overlap=1: stream 1,0,1,1,0,1,1 -> detect pulses after bit 4 and bit 7. Overlap=0, same stream -> detect after bit 4 only; armed drops to 0 after the match.
- Run-length case: cfg_load pattern 0000, mask 1111, then six 0s:
  - overlap=1 -> 3 detects (bits 4,5,6).
  - overlap=0 -> 1 detect (bit 4).
- Mask and gaps:
  - pattern 1001, mask 1001, stream 1,1,0,1 with in_valid gaps of 2 idle cycles between bits -> a single detect after bit 4, and detect=0 during the idle cycles.
- Config collision: cfg_load and in_valid in the same cycle -> bit discarded, armed=0. A match needs 4 further bits. Assert reset_n low after 3 bits -> no detect until 4 new bits are received.
- MATCH_COUNT_EN with CNT_W=2: 5 overlapping matches -> match_count=3 (saturated). Pulse count_clr in the same cycle as a detect -> match_count=0.

Source files
------------

// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector with don't-care mask and overlap control.
// Optional saturating match counter enabled by defining MATCH_COUNT_EN.
//
// state   | meaning
// EMPTY   | no valid history bits (fill = 0)
// FILLING | 0 < fill < PATTERN_W
// ARMED   | history holds PATTERN_W valid bits
module seq_detect_param #(
    parameter int                   PATTERN_W   = 4,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = 4'b1011,
    parameter int                   CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic                 inbit,
    input  logic                 overlap,
    input  logic                 cfg_load,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic [PATTERN_W-1:0] cfg_mask,
    output logic                 detect,
    output logic                 armed,
    output logic [CNT_W-1:0]     match_count,
    input  logic                 count_clr
);

    localparam int FILL_W = $clog2(PATTERN_W + 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PATTERN_W-1:0] hist_q, hist_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic [PATTERN_W-1:0] mask_q, mask_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 detect_q, detect_d;
    logic                 armed_q, armed_d;

    logic [PATTERN_W-1:0] next_hist;
    logic [FILL_W:0]      fill_p1;
    logic                 fill_full;
    logic                 match;

    // fill_p1 carries an extra bit so fill+1 never wraps for any PATTERN_W
    assign next_hist = {hist_q[PATTERN_W-2:0], inbit};
    assign fill_p1   = {1'b0, fill_q} + 1'b1;
    assign fill_full = (fill_p1 >= (FILL_W+1)'(PATTERN_W));
    assign match     = in_valid & fill_full & (((next_hist ^ pattern_q) & mask_q) == '0);

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        pattern_d = pattern_q;
        mask_d    = mask_q;
        fill_d    = fill_q;
        detect_d  = 1'b0;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            mask_d    = cfg_mask;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = EMPTY;
        end else if (in_valid) begin
            detect_d = match;
            if (match && !overlap) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = EMPTY;
            end else begin
                hist_d  = next_hist;
                fill_d  = fill_full ? FILL_W'(PATTERN_W) : fill_p1[FILL_W-1:0];
                state_d = fill_full ? ARMED : FILLING;
            end
        end
        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            hist_q    <= '0;
            pattern_q <= PATTERN_RST;
            mask_q    <= '1;
            fill_q    <= '0;
            detect_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            fill_q    <= fill_d;
            detect_q  <= detect_d;
            armed_q   <= armed_d;
        end
    end

    assign detect = detect_q;
    assign armed  = armed_q;

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    // clear takes priority over a coincident increment
    always_comb begin
        count_d = count_q;
        if (count_clr) begin
            count_d = '0;
        end else if (detect_q && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`else
    logic unused_count_clr;

    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: fill/match timing, overlap, mask, config and reset.
// The counter checks follow MATCH_COUNT_EN the same way the design does.
module tb_seq_detect_param;

    localparam int PW    = 4;
    localparam int CNT_W = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          inbit;
    logic          overlap;
    logic          cfg_load;
    logic [PW-1:0] cfg_pattern;
    logic [PW-1:0] cfg_mask;
    logic          detect;
    logic          armed;
    logic [CNT_W-1:0] match_count;
    logic          count_clr;

    int checks   = 0;
    int failures = 0;

    seq_detect_param #(
        .PATTERN_W  (PW),
        .PATTERN_RST(4'b1011),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .inbit      (inbit),
        .overlap    (overlap),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_mask   (cfg_mask),
        .detect     (detect),
        .armed      (armed),
        .match_count(match_count),
        .count_clr  (count_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drive inputs from a falling edge, return at the next falling edge
    task automatic step(input logic v, input logic b);
        in_valid = v;
        inbit    = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_cfg(input logic [PW-1:0] pat, input logic [PW-1:0] msk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_mask    = msk;
        step(1'b0, 1'b0);
        cfg_load    = 1'b0;
    endtask

    // bits sent MSB first; exp_det bit order matches
    task automatic run_stream(input string tag, input int n,
                              input logic [31:0] bits, input logic [31:0] exp_det);
        logic [31:0] b;
        logic [31:0] e;
        b = bits;
        e = exp_det;
        for (int i = 0; i < n; i++) begin
            step(1'b1, b[n-1-i]);
            chk($sformatf("%s_det_b%0d", tag, i + 1), {31'd0, detect}, {31'd0, e[n-1-i]});
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        inbit       = 1'b0;
        overlap     = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_mask    = '0;
        count_clr   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_detect", {31'd0, detect}, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_count", {30'd0, match_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // default pattern 1011, basic match
        run_stream("basic", 3, 32'b101, 32'b000);
        chk("basic_armed_b3", {31'd0, armed}, 32'd0);
        run_stream("basic4", 1, 32'b1, 32'b1);
        chk("basic_armed_b4", {31'd0, armed}, 32'd1);
        step(1'b0, 1'b0);
        chk("basic_idle_det", {31'd0, detect}, 32'd0);
        chk("basic_idle_armed", {31'd0, armed}, 32'd1);

        // overlap on/off with 1011011
        load_cfg(4'b1011, 4'b1111);
        chk("cfg_armed_clr", {31'd0, armed}, 32'd0);
        overlap = 1'b1;
        run_stream("ovl1", 7, 32'b1011011, 32'b0001001);
        load_cfg(4'b1011, 4'b1111);
        overlap = 1'b0;
        run_stream("ovl0a", 4, 32'b1011, 32'b0001);
        chk("ovl0_armed_drop", {31'd0, armed}, 32'd0);
        run_stream("ovl0b", 3, 32'b011, 32'b000);
        chk("ovl0_armed_end", {31'd0, armed}, 32'd0);

        // run-length of zeros
        load_cfg(4'b0000, 4'b1111);
        overlap = 1'b1;
        run_stream("run1", 6, 32'b000000, 32'b000111);
        load_cfg(4'b0000, 4'b1111);
        overlap = 1'b0;
        run_stream("run0", 6, 32'b000000, 32'b000100);

        // masked compare with idle gaps
        load_cfg(4'b1001, 4'b1001);
        overlap = 1'b1;
        begin
            logic [3:0] gb;
            gb = 4'b1101;
            for (int i = 0; i < 4; i++) begin
                step(1'b1, gb[3-i]);
                chk($sformatf("gap_det_b%0d", i + 1), {31'd0, detect}, {31'd0, (i == 3)});
                for (int k = 0; k < 2; k++) begin
                    step(1'b0, 1'b1);
                    chk($sformatf("gap_idle_b%0d_%0d", i + 1, k), {31'd0, detect}, 32'd0);
                end
            end
        end

        // cfg_load colliding with a bit that would otherwise complete 1011
        load_cfg(4'b1011, 4'b1111);
        run_stream("coll_pre", 3, 32'b101, 32'b000);
        cfg_load    = 1'b1;
        cfg_pattern = 4'b1011;
        cfg_mask    = 4'b1111;
        step(1'b1, 1'b1);
        cfg_load    = 1'b0;
        chk("coll_det", {31'd0, detect}, 32'd0);
        chk("coll_armed", {31'd0, armed}, 32'd0);
        run_stream("coll_post3", 3, 32'b101, 32'b000);
        chk("coll_armed3", {31'd0, armed}, 32'd0);
        run_stream("coll_post4", 1, 32'b1, 32'b1);

        // reset mid-stream discards partial history
        load_cfg(4'b1011, 4'b1111);
        run_stream("rst_pre", 3, 32'b101, 32'b000);
        reset_n = 1'b0;
        #2;
        chk("midrst_armed", {31'd0, armed}, 32'd0);
        chk("midrst_det", {31'd0, detect}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_stream("rst_post", 4, 32'b1011, 32'b0001);

        // all-don't-care mask: every armed bit matches, exercises counter saturation
        load_cfg(4'b0000, 4'b0000);
        count_clr = 1'b1;
        step(1'b0, 1'b0);
        count_clr = 1'b0;
        overlap   = 1'b1;
        run_stream("mask0", 8, 32'b10110010, 32'b00011111);
`ifdef MATCH_COUNT_EN
        chk("cnt_sat", {30'd0, match_count}, 32'd3);
        count_clr = 1'b1;
        step(1'b0, 1'b0);
        count_clr = 1'b0;
        chk("cnt_clr_win", {30'd0, match_count}, 32'd0);
        step(1'b0, 1'b0);
        chk("cnt_after_clr", {30'd0, match_count}, 32'd0);
`else
        chk("cnt_off", {30'd0, match_count}, 32'd0);
        step(1'b0, 1'b0);
        chk("cnt_off_idle", {30'd0, match_count}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
